// File: rtl/endpoint_flit_tx.sv
// ---------------------------------------------------------------------------
// endpoint_flit_tx
//
// Credit-based flit transmitter feeding one switch input port. Flits offered
// by the source are staged in an in-order FIFO together with their target VC.
// The head is issued to the switch only while its VC holds at least one
// credit. Each issue consumes a credit, and each credit_granted pulse returns
// one. The head is never bypassed, so a stalled head blocks every later flit
// (strict head-of-line order).
//
// Handshake: a flit transfers from the source on any rising edge where
// req_valid & req_ready are both high. req_ready depends only on FIFO fullness,
// not on a same-cycle pop. data_ready is a one-cycle strobe qualifying
// out_flit. The switch has no back-pressure beyond the credits.
//
// Optional feature (macro ENDPOINT_TX_CREDIT_CHECK_EN): when it is defined, a
// credit grant that arrives with the VC already at BUFFER_SIZE sets the sticky
// credit_overflow flag. When it is undefined, credit_overflow is tied to 0.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   source handshake; req_flit + req_vc are the payload
//   out_flit          last issued flit (holds between issues)
//   data_ready        one-cycle strobe per issued flit
//   credit_granted    per-VC credit return pulses
//   credits           per-VC credit counts, VC0 in the LSBs
//   busy              FIFO non-empty or a flit strobe in progress
//   credit_overflow   sticky saturated-grant flag
//   dbg_state         FSM state (0 IDLE, 1 SEND, 2 STALL)
// ---------------------------------------------------------------------------
module endpoint_flit_tx #(
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int FLIT_W      = 32,
    localparam int VC_W       = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int CR_W       = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic [FLIT_W-1:0]         req_flit,
    input  logic [VC_W-1:0]           req_vc,
    output logic                      req_ready,
    output logic [FLIT_W-1:0]         out_flit,
    output logic                      data_ready,
    input  logic [NUM_VCS-1:0]        credit_granted,
    output logic [NUM_VCS*CR_W-1:0]   credits,
    output logic                      busy,
    output logic                      credit_overflow,
    output logic [1:0]                dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    logic [FLIT_W-1:0] r_fifo_flit [FIFO_DEPTH];
    logic [VC_W-1:0]   r_fifo_vc   [FIFO_DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic [CR_W-1:0]   r_credits   [NUM_VCS];
    state_t            r_state;
    logic              r_data_ready;
    logic [FLIT_W-1:0] r_out_flit;

    logic [PTR_W:0]    w_count;
    logic [PTR_W:0]    w_count_next;
    logic [PTR_W:0]    w_rd_ptr_next;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [VC_W-1:0]   w_head_vc;
    logic [VC_W-1:0]   w_next_head_vc;
    logic [NUM_VCS-1:0] w_dec_vec;
    logic [NUM_VCS-1:0] w_at_max;
    logic [CR_W-1:0]   w_credits_next [NUM_VCS];
    state_t            w_state_next;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (w_count == '0);
    assign w_full    = (w_count == (PTR_W+1)'(FIFO_DEPTH));
    assign req_ready = ~rst & ~w_full;
    assign w_push    = req_valid & req_ready;
    // The state register is kept exact for the current cycle, so SEND means
    // "head present with a credit": issue is decided by the state alone.
    assign w_pop     = (r_state == S_SEND);
    assign w_head_vc = r_fifo_vc[r_rd_ptr[PTR_W-1:0]];

    assign w_rd_ptr_next = r_rd_ptr + (PTR_W+1)'(w_pop);
    assign w_count_next  = w_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    // A single remaining entry after a push must be the one being pushed.
    assign w_next_head_vc = (w_push && w_count_next == (PTR_W+1)'(1))
                          ? req_vc : r_fifo_vc[w_rd_ptr_next[PTR_W-1:0]];

    always_comb begin
        w_dec_vec = '0;
        w_at_max  = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            w_dec_vec[v] = w_pop && (w_head_vc == VC_W'(v));
            w_at_max[v]  = (r_credits[v] == CR_W'(BUFFER_SIZE));
        end
    end

    // A grant and an issue on the same VC cancel. A lone grant at the maximum
    // is dropped (saturate).
    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            w_credits_next[v] = r_credits[v];
            if (credit_granted[v] && !w_dec_vec[v] && !w_at_max[v])
                w_credits_next[v] = r_credits[v] + CR_W'(1);
            else if (w_dec_vec[v] && !credit_granted[v])
                w_credits_next[v] = r_credits[v] - CR_W'(1);
        end
    end

    always_comb begin
        w_state_next = S_IDLE;
        if (w_count_next != '0)
            w_state_next = (w_credits_next[w_next_head_vc] != '0) ? S_SEND : S_STALL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_state      <= S_IDLE;
            r_data_ready <= 1'b0;
            r_out_flit   <= '0;
            for (int v = 0; v < NUM_VCS; v++)
                r_credits[v] <= CR_W'(BUFFER_SIZE);
        end else begin
            r_state      <= w_state_next;
            r_data_ready <= w_pop;
            for (int v = 0; v < NUM_VCS; v++)
                r_credits[v] <= w_credits_next[v];
            if (w_push)
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop) begin
                r_rd_ptr   <= w_rd_ptr_next;
                r_out_flit <= r_fifo_flit[r_rd_ptr[PTR_W-1:0]];
            end
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_flit[r_wr_ptr[PTR_W-1:0]] <= req_flit;
            r_fifo_vc[r_wr_ptr[PTR_W-1:0]]   <= req_vc;
        end
    end

`ifdef ENDPOINT_TX_CREDIT_CHECK_EN
    logic r_overflow;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_overflow <= 1'b0;
        else if (|(credit_granted & w_at_max & ~w_dec_vec))
            r_overflow <= 1'b1;
    end
    assign credit_overflow = r_overflow;
`else
    assign credit_overflow = 1'b0;
`endif

    always_comb begin
        credits = '0;
        for (int v = 0; v < NUM_VCS; v++)
            credits[v*CR_W +: CR_W] = r_credits[v];
    end

    assign out_flit   = r_out_flit;
    assign data_ready = r_data_ready;
    assign busy       = ~w_empty | r_data_ready;
    assign dbg_state  = r_state;

endmodule

// File: doc/endpoint_flit_tx.md
ENDPOINT_FLIT_TX -- requirements
Module: endpoint_flit_tx

Interface
REQ-001 SHALL have parameter NUM_VCS, default 2, meaning the number of virtual channels on the switch input port.
REQ-002 SHALL have parameter BUFFER_SIZE, default 8, meaning the initial and maximum credits per VC (the switch buffer depth).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the local staging FIFO entries (power of 2, at least 2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1 bit: the source offers a flit.
REQ-007 SHALL have port req_flit, input, flit_t: the offered flit.
REQ-008 SHALL have port req_vc, input, clog2(NUM_VCS) bits: the target VC of the offered flit.
REQ-009 SHALL have port req_ready, output, 1 bit: the FIFO can accept a flit; the transfer occurs on req_valid & req_ready.
REQ-010 SHALL have port out_flit, output, flit_t: the flit driven to the switch in[] port.
REQ-011 SHALL have port data_ready, output, 1 bit: drives the switch data_ready_in; high for exactly one cycle per flit.
REQ-012 SHALL have port credit_granted, input, NUM_VCS bits: a one-cycle pulse on bit v returns one credit to VC v.
REQ-013 SHALL have port credits, output, NUM_VCS*clog2(BUFFER_SIZE+1) bits: the current credit count per VC, with VC0 in the LSBs.
REQ-014 SHALL have port busy, output, 1 bit: high when the FIFO is non-empty or data_ready is high.
REQ-015 SHALL have port credit_overflow, output, 1 bit: a sticky error flag (see Configuration).

Function
REQ-016 SHALL store accepted {flit, vc} in an in-order FIFO; req_ready = not full, regardless of a same-cycle pop.
REQ-017 SHALL implement the FSM IDLE (FIFO empty), SEND (issue this edge), and STALL (head present, credits[head.vc]==0).
REQ-018 SHALL, on each edge with head present and credits[head.vc]>0, pop the head, register out_flit, set data_ready=1 for the next cycle, and decrement credits[head.vc].
REQ-019 SHALL deassert data_ready in any cycle following an edge with no issue; out_flit SHALL hold its last value.
REQ-020 SHALL support a sustained throughput of 1 flit/cycle while credits last; minimum latency is a flit accepted at edge E with data_ready high in the cycle after edge E+1.
REQ-021 SHALL enforce strict head-of-line order; a stalled head blocks later flits even on other VCs.
REQ-022 SHALL increment credits[v] on a credit_granted[v] pulse; a grant and issue on the same VC in the same cycle SHALL leave the count unchanged.
REQ-023 SHALL ignore a grant arriving when credits[v]==BUFFER_SIZE with no same-cycle issue on v (saturate).
REQ-024 SHALL, in STALL, move to SEND on the edge after the head's VC credit becomes nonzero.
REQ-025 SHALL never let a push into a full FIFO corrupt state; the pointers wrap modulo FIFO_DEPTH.

Reset
REQ-026 SHALL, while rst is high, hold the FIFO empty, state=IDLE, credits[v]=BUFFER_SIZE, data_ready=0, out_flit=0, busy=0, credit_overflow=0, and req_ready=0.
REQ-027 SHALL, when rst asserts mid-operation, discard queued and in-flight flits immediately, with no partial data_ready pulse; req_ready=1 on the first cycle after release.

Configuration
REQ-028 SHALL, with macro ENDPOINT_TX_CREDIT_CHECK_EN defined, set credit_overflow on any saturated grant (REQ-023) and hold it until reset.
REQ-029 SHALL, without ENDPOINT_TX_CREDIT_CHECK_EN, tie credit_overflow to 0 and silently ignore saturated grants.

Verification
REQ-030 Bench SHALL cover: push 3 flits on VC0 at cycles 0-2 -> data_ready high in cycles 2,3,4 in order; credits VC0 = 5.
REQ-031 Bench SHALL cover: 8 flits on VC1 with no grants, then a 9th on VC1 -> 8 issued, 9th stalls (STALL), credits VC1 = 0; a grant on VC1 -> 9th issued 1 cycle later.
REQ-032 Bench SHALL cover: VC0 credits at 0 with head on VC0 and the next flit on VC1 -> the VC1 flit is not issued until the VC0 head issues.
REQ-033 Bench SHALL cover: simultaneous issue and grant on VC0 with credits 3 -> credits stay 3.
REQ-034 Bench SHALL cover: fill FIFO (4 entries, credits 0) -> req_ready=0; a 5th req_valid is not accepted.
REQ-035 Bench SHALL cover: a grant on VC0 at credits 8 -> credits stay 8; credit_overflow=1 with macro, 0 without; rst mid-stream -> all outputs at reset values.
